// File: rtl/uart_tx_serializer.sv
// 16550-style transmit serializer: pops characters from the TX FIFO and shifts
// them out on txd as start / 5-8 data / optional parity / 1-2 stop bit frames.
module uart_tx_serializer #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_rd_valid,
  input  logic [7:0]       lcr,
  output logic             txd,
  output logic             tx_busy,
  output logic             tx_idle
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam logic [4:0] TICK_BIT    = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] TICK_STOP15 = 5'(OVERSAMPLE + (OVERSAMPLE / 2) - 1);
  localparam logic [4:0] TICK_STOP2  = 5'(2 * OVERSAMPLE - 1);

  // Parity over the transmitted data bits only; stick parity overrides
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps, input logic stick);
    logic [7:0] mask;
    logic       x;
    case (wls)
      2'd0:    mask = 8'h1F;
      2'd1:    mask = 8'h3F;
      2'd2:    mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (stick) begin
      calc_parity = ~eps;
    end else if (eps) begin
      calc_parity = x;
    end else begin
      calc_parity = ~x;
    end
  endfunction

  state_t     state_r, state_next_s;
  logic [4:0] tick_cnt_r, tick_next_s;
  logic [2:0] bit_cnt_r, bit_next_s, bit_last_s;
  logic [7:0] shift_r, shift_next_s;
  logic [1:0] fmt_wls_r;
  logic       fmt_stb_r, fmt_pen_r, parity_r;
  logic       fetch_wait_r, fetch_wait_next_s;
  logic       pop_s, load_s, txd_next_s;
  logic [4:0] stop_last_s;
  logic       txd_r, rd_en_r, busy_r;
  logic       unused_s;

  assign unused_s   = ^{lcr[7], fifo_rd_data};
  assign bit_last_s = 3'd4 + {1'b0, fmt_wls_r};

  assign txd        = txd_r;
  assign fifo_rd_en = rd_en_r;
  assign tx_busy    = busy_r;
  assign tx_idle    = fifo_empty && !busy_r;

  // Next-state, counter and output decode
  always_comb begin
    state_next_s      = state_r;
    tick_next_s       = tick_cnt_r;
    bit_next_s        = bit_cnt_r;
    shift_next_s      = shift_r;
    fetch_wait_next_s = 1'b0;
    pop_s             = 1'b0;
    load_s            = 1'b0;
    txd_next_s        = 1'b1;

    if (!fmt_stb_r) begin
      stop_last_s = TICK_BIT;
    end else if (fmt_wls_r == 2'd0) begin
      stop_last_s = TICK_STOP15;
    end else begin
      stop_last_s = TICK_STOP2;
    end

    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_s        = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // First cycle only lets the pop land; rd_valid is sampled on the second
        if (!fetch_wait_r) begin
          fetch_wait_next_s = 1'b1;
        end else if (fifo_rd_valid) begin
          load_s       = 1'b1;
          shift_next_s = fifo_rd_data[7:0];
          tick_next_s  = 5'd0;
          bit_next_s   = 3'd0;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START, ST_PARITY: begin
        if (baud_tick) begin
          if (tick_cnt_r == TICK_BIT) begin
            tick_next_s = 5'd0;
            if (state_r == ST_START) begin
              state_next_s = ST_DATA;
            end else begin
              state_next_s = ST_STOP;
            end
          end else begin
            tick_next_s = tick_cnt_r + 5'd1;
          end
        end else begin
          tick_next_s = tick_cnt_r;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (tick_cnt_r == TICK_BIT) begin
            tick_next_s  = 5'd0;
            shift_next_s = {1'b0, shift_r[7:1]};
            if (bit_cnt_r == bit_last_s) begin
              bit_next_s = 3'd0;
              if (fmt_pen_r) begin
                state_next_s = ST_PARITY;
              end else begin
                state_next_s = ST_STOP;
              end
            end else begin
              bit_next_s = bit_cnt_r + 3'd1;
            end
          end else begin
            tick_next_s = tick_cnt_r + 5'd1;
          end
        end else begin
          tick_next_s = tick_cnt_r;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (tick_cnt_r == stop_last_s) begin
            tick_next_s = 5'd0;
            if (!fifo_empty) begin
              pop_s        = 1'b1;
              state_next_s = ST_FETCH;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            tick_next_s = tick_cnt_r + 5'd1;
          end
        end else begin
          tick_next_s = tick_cnt_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    case (state_next_s)
      ST_START:  txd_next_s = 1'b0;
      ST_DATA:   txd_next_s = shift_next_s[0];
      ST_PARITY: txd_next_s = parity_r;
      default:   txd_next_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs; break overrides txd live
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      tick_cnt_r   <= 5'd0;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      fetch_wait_r <= 1'b0;
      txd_r        <= 1'b1;
      rd_en_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      tick_cnt_r   <= tick_next_s;
      bit_cnt_r    <= bit_next_s;
      shift_r      <= shift_next_s;
      fetch_wait_r <= fetch_wait_next_s;
      txd_r        <= lcr[6] ? 1'b0 : txd_next_s;
      rd_en_r      <= pop_s;
      busy_r       <= (state_next_s != ST_IDLE);
    end
  end

  // Per-character frame format and precomputed parity bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fmt_wls_r <= 2'd0;
      fmt_stb_r <= 1'b0;
      fmt_pen_r <= 1'b0;
      parity_r  <= 1'b0;
    end else if (load_s) begin
      fmt_wls_r <= lcr[1:0];
      fmt_stb_r <= lcr[2];
      fmt_pen_r <= lcr[3];
      parity_r  <= calc_parity(fifo_rd_data[7:0], lcr[1:0], lcr[4], lcr[5]);
    end else begin
      fmt_wls_r <= fmt_wls_r;
      fmt_stb_r <= fmt_stb_r;
      fmt_pen_r <= fmt_pen_r;
      parity_r  <= parity_r;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a small FIFO model feeds the DUT and
// txd/tx_busy are traced at negedges, then checked against hand-derived frames.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_valid = 1'b0;
  logic [7:0] lcr = 8'h03;
  logic       txd, tx_busy, tx_idle;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [0:31];
  int wr_ptr = 0, rd_ptr = 0, pop_cnt = 0, div = 0;
  logic trace_txd  [0:16383];
  logic trace_busy [0:16383];

  always #5 clk = ~clk;
  assign fifo_empty = (wr_ptr == rd_ptr);

  uart_tx_serializer #(.WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid),
    .lcr(lcr), .txd(txd), .tx_busy(tx_busy), .tx_idle(tx_idle)
  );

  // baud strobe every 4 clk
  always @(posedge clk) begin
    div       <= (div == 3) ? 0 : div + 1;
    baud_tick <= (div == 3);
  end

  // FIFO model: data and rd_valid the cycle after rd_en
  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data  <= mem[rd_ptr % 32];
      rd_ptr        <= rd_ptr + 1;
      fifo_rd_valid <= 1'b1;
    end else begin
      fifo_rd_valid <= 1'b0;
    end
    if (fifo_rd_en) pop_cnt <= pop_cnt + 1;
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 32] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      trace_txd[i]  = txd;
      trace_busy[i] = tx_busy;
    end
  endtask

  function automatic int find_level(input int from, input int lim, input logic lvl);
    if (from < 0) return -1;
    for (int i = from; i < lim; i++) if (trace_txd[i] === lvl) return i;
    return -1;
  endfunction

  function automatic int find_busy_low(input int from, input int lim);
    if (from < 0) return -1;
    for (int i = from; i < lim; i++) if (trace_busy[i] === 1'b0) return i;
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_vec++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_vec++; if (tx_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b expected 1", tx_idle); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_vec++; if (txd !== 1'b1 || pop_cnt != 0) begin
      n_err++; $display("FAIL reset_release: txd %b pops %0d expected 1 / 0", txd, pop_cnt);
    end
  endtask

  task automatic test_8n1;
    logic [9:0] exp_bits;
    int s, rise, fall, b, len, p0;
    exp_bits = 10'b1101001010;
    lcr = 8'h03;
    p0 = pop_cnt;
    push(8'hA5);
    capture(800);
    s = find_level(0, 800, 1'b0);
    n_vec++; if (s < 0 || s > 8) begin n_err++; $display("FAIL 8n1_start_pos: got %0d expected 0..8", s); end
    if (s < 0) s = 0;
    for (int k = 0; k < 10; k++) begin
      n_vec++;
      if (trace_txd[s + 64*k + 30] !== exp_bits[k]) begin
        n_err++; $display("FAIL 8n1_bit%0d: got %b expected %b", k, trace_txd[s + 64*k + 30], exp_bits[k]);
      end
    end
    rise = find_level(s, 800, 1'b1);
    len  = rise - s;
    n_vec++; if (len < 61 || len > 64) begin n_err++; $display("FAIL 8n1_start_len: got %0d expected 61..64", len); end
    fall = find_level(rise, 800, 1'b0);
    n_vec++; if (fall - rise != 64) begin n_err++; $display("FAIL 8n1_bit_len: got %0d expected 64", fall - rise); end
    b = find_busy_low(s, 800);
    n_vec++; if (b != s + len + 576) begin n_err++; $display("FAIL 8n1_frame_end: got %0d expected %0d", b, s + len + 576); end
    n_vec++; if (tx_idle !== 1'b1) begin n_err++; $display("FAIL 8n1_idle: got %b expected 1", tx_idle); end
    n_vec++; if (pop_cnt - p0 != 1) begin n_err++; $display("FAIL 8n1_pops: got %0d expected 1", pop_cnt - p0); end
  endtask

  task automatic test_parity;
    logic [7:0] t_lcr  [0:2];
    logic [7:0] t_data [0:2];
    logic [9:0] t_bits [0:2];
    int         t_roff [0:2];
    logic [9:0] eb;
    int s, rise, len, b;
    t_lcr[0] = 8'h1A; t_data[0] = 8'h7F; t_bits[0] = 10'b1111111110; t_roff[0] = 0;
    t_lcr[1] = 8'h2A; t_data[1] = 8'h00; t_bits[1] = 10'b1100000000; t_roff[1] = 448;
    t_lcr[2] = 8'h0A; t_data[2] = 8'h7F; t_bits[2] = 10'b1011111110; t_roff[2] = 0;
    for (int v = 0; v < 3; v++) begin
      lcr = t_lcr[v];
      eb  = t_bits[v];
      push(t_data[v]);
      capture(800);
      s = find_level(0, 800, 1'b0);
      n_vec++; if (s < 0 || s > 8) begin n_err++; $display("FAIL par%0d_start_pos: got %0d expected 0..8", v, s); end
      if (s < 0) s = 0;
      for (int k = 0; k < 10; k++) begin
        n_vec++;
        if (trace_txd[s + 64*k + 30] !== eb[k]) begin
          n_err++; $display("FAIL par%0d_bit%0d: got %b expected %b", v, k, trace_txd[s + 64*k + 30], eb[k]);
        end
      end
      rise = find_level(s, 800, 1'b1);
      len  = rise - s - t_roff[v];
      b    = find_busy_low(s, 800);
      n_vec++; if (b != s + len + 576) begin n_err++; $display("FAIL par%0d_frame_end: got %0d expected %0d", v, b, s + len + 576); end
    end
  endtask

  task automatic test_5bit_15stop;
    int s, rise, len, b, p0;
    lcr = 8'h04;
    p0 = pop_cnt;
    push(8'hFF);
    capture(600);
    s = find_level(0, 600, 1'b0);
    if (s < 0) s = 0;
    rise = find_level(s, 600, 1'b1);
    len  = rise - s;
    n_vec++; if (len < 61 || len > 64) begin n_err++; $display("FAIL 5b_start_len: got %0d expected 61..64", len); end
    b = find_busy_low(s, 600);
    n_vec++; if (b != s + len + 416) begin n_err++; $display("FAIL 5b_frame_end: got %0d expected %0d", b, s + len + 416); end
    n_vec++; if (find_level(rise, 600, 1'b0) != -1) begin n_err++; $display("FAIL 5b_no_low: got low at %0d expected none", find_level(rise, 600, 1'b0)); end
    n_vec++; if (pop_cnt - p0 != 1) begin n_err++; $display("FAIL 5b_pops: got %0d expected 1", pop_cnt - p0); end
  endtask

  task automatic test_back_to_back;
    int s, rise, nxt, p0, gaps;
    logic [7:0] got;
    int first_s, last_rise;
    lcr = 8'h03;
    p0 = pop_cnt;
    for (int i = 0; i < 16; i++) push(8'(i));
    capture(10600);
    s = find_level(0, 10600, 1'b0);
    first_s = s;
    last_rise = s;
    for (int i = 0; i < 16; i++) begin
      if (s < 0) begin
        n_vec++; n_err++; $display("FAIL b2b_frame%0d_missing: got none expected start", i);
        break;
      end
      for (int k = 0; k < 8; k++) got[k] = trace_txd[s + 64*(k+1) + 30];
      n_vec++; if (got !== 8'(i)) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", i, got, 8'(i)); end
      rise = find_level(s + 520, 10600, 1'b1);
      last_rise = rise;
      if (i < 15) begin
        nxt = find_level(rise, 10600, 1'b0);
        n_vec++; if (nxt - rise != 66) begin n_err++; $display("FAIL b2b_gap%0d: got %0d expected 66", i, nxt - rise); end
        s = nxt;
      end
    end
    gaps = 0;
    if (first_s >= 0 && last_rise >= 0)
      for (int i = first_s; i < last_rise; i++) if (trace_busy[i] !== 1'b1) gaps++;
    n_vec++; if (gaps != 0) begin n_err++; $display("FAIL b2b_busy: got %0d idle cycles expected 0", gaps); end
    n_vec++; if (pop_cnt - p0 != 16) begin n_err++; $display("FAIL b2b_pops: got %0d expected 16", pop_cnt - p0); end
    n_vec++; if (tx_idle !== 1'b1 || fifo_empty !== 1'b1) begin
      n_err++; $display("FAIL b2b_idle: got idle %b empty %b expected 1 1", tx_idle, fifo_empty);
    end
  endtask

  task automatic test_break;
    int waited, ones;
    lcr = 8'h03;
    push(8'hFF);
    waited = 0;
    while (txd !== 1'b0 && waited < 200) begin @(negedge clk); waited++; end
    n_vec++; if (waited >= 200) begin n_err++; $display("FAIL brk_start: got no start bit expected within 200"); end
    repeat (138) @(negedge clk);
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL brk_pre: got %b expected 1", txd); end
    lcr = 8'h43;
    @(negedge clk);
    n_vec++; if (txd !== 1'b0) begin n_err++; $display("FAIL brk_assert: got %b expected 0", txd); end
    ones = 0;
    repeat (100) begin @(negedge clk); if (txd !== 1'b0) ones++; end
    n_vec++; if (ones != 0) begin n_err++; $display("FAIL brk_hold: got %0d high cycles expected 0", ones); end
    lcr = 8'h03;
    @(negedge clk);
    n_vec++; if (txd !== 1'b1 || tx_busy !== 1'b1) begin
      n_err++; $display("FAIL brk_resume: got txd %b busy %b expected 1 1", txd, tx_busy);
    end
    waited = 0;
    while (tx_busy !== 1'b0 && waited < 1000) begin @(negedge clk); waited++; end
    n_vec++; if (tx_idle !== 1'b1) begin n_err++; $display("FAIL brk_end_idle: got %b expected 1", tx_idle); end
  endtask

  task automatic test_reset_mid_frame;
    int waited, lows, p0;
    lcr = 8'h03;
    push(8'h00);
    waited = 0;
    while (txd !== 1'b0 && waited < 200) begin @(negedge clk); waited++; end
    repeat (150) @(negedge clk);
    n_vec++; if (tx_busy !== 1'b1 || txd !== 1'b0) begin
      n_err++; $display("FAIL rstm_pre: got busy %b txd %b expected 1 0", tx_busy, txd);
    end
    rst = 1'b1;
    #1;
    n_vec++; if (txd !== 1'b1) begin n_err++; $display("FAIL rstm_txd: got %b expected 1", txd); end
    n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL rstm_busy: got %b expected 0", tx_busy); end
    @(negedge clk);
    rst = 1'b0;
    p0 = pop_cnt;
    capture(300);
    lows = 0;
    for (int i = 0; i < 300; i++) if (trace_txd[i] !== 1'b1) lows++;
    n_vec++; if (lows != 0) begin n_err++; $display("FAIL rstm_txd_after: got %0d low cycles expected 0", lows); end
    n_vec++; if (pop_cnt != p0) begin n_err++; $display("FAIL rstm_pops: got %0d expected 0", pop_cnt - p0); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_5bit_15stop();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
